// File: rtl/vga_display_zoom.sv
// -----------------------------------------------------------------------------
// vga_display_zoom
//   Shows a c_img_cols x c_img_rows frame buffer at the top-left of a 640x480
//   screen, replicated by 1, 2, 4 or 8 in both directions. A cyan 1-pixel
//   border frames the displayed area and an optional yellow rectangle
//   (in image coordinates) is drawn on top of the image.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   visible, new_pxl          sync generator: visible area, one pulse per pixel
//   hsync, vsync              syncs from the generator (active low)
//   col, row                  current screen position
//   rgbmode                   1: buffer word is R,G,B; 0: grey in bits [7:4]
//   zoom_sel                  requested zoom (0..3 -> x1..x8), taken per frame
//   box_en, box_*             bounding-box overlay, image coordinates
//   frame_pixel, frame_addr   frame-buffer read port (read latency c_mem_lat)
//   vga_red/green/blue        registered colour
//   vga_hsync, vga_vsync      syncs delayed to line up with the colour
// -----------------------------------------------------------------------------
module vga_display_zoom #(
    parameter int c_img_cols     = 80,
    parameter int c_img_rows     = 60,
    parameter int c_nb_img_pxls  = 13,
    parameter int c_nb_buf_red   = 4,
    parameter int c_nb_buf_green = 4,
    parameter int c_nb_buf_blue  = 4,
    parameter int c_nb_buf       = 12,
    parameter int c_mem_lat      = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     visible,
    input  logic                     new_pxl,
    input  logic                     hsync,
    input  logic                     vsync,
    input  logic [9:0]               col,
    input  logic [9:0]               row,
    input  logic                     rgbmode,
    input  logic [1:0]               zoom_sel,
    input  logic                     box_en,
    input  logic [6:0]               box_xmin,
    input  logic [6:0]               box_xmax,
    input  logic [5:0]               box_ymin,
    input  logic [5:0]               box_ymax,
    input  logic [c_nb_buf-1:0]      frame_pixel,
    output logic [c_nb_img_pxls-1:0] frame_addr,
    output logic [3:0]               vga_red,
    output logic [3:0]               vga_green,
    output logic [3:0]               vga_blue,
    output logic                     vga_hsync,
    output logic                     vga_vsync
);

    // 11-bit screen arithmetic: W and H reach 640/480 at x8, so the compares
    // against col/row must not wrap.
    localparam logic [10:0] c_cols_s = 11'(c_img_cols);
    localparam logic [10:0] c_rows_s = 11'(c_img_rows);
    localparam logic [c_nb_img_pxls-1:0] c_line_step = c_nb_img_pxls'(c_img_cols);
    localparam logic [c_nb_img_pxls-1:0] c_last_line = c_nb_img_pxls'((c_img_rows - 1) * c_img_cols);

    typedef struct packed {
        logic visible;
        logic hsync;
        logic vsync;
        logic in_img;
        logic on_border;
        logic on_box;
    } stage_t;

    localparam stage_t c_stage_rst = '{visible: 1'b0, hsync: 1'b1, vsync: 1'b1,
                                       in_img: 1'b0, on_border: 1'b0, on_box: 1'b0};

    logic [1:0]               zoom_q, zoom_d;
    logic                     vsync_q, vsync_d;
    logic [c_nb_img_pxls-1:0] frame_addr_q, frame_addr_d;
    logic [c_nb_img_pxls-1:0] line_base_q, line_base_d;
    logic [2:0]               hsub_q, hsub_d, vsub_q, vsub_d;
    logic [3:0]               red_q, red_d, green_q, green_d, blue_q, blue_d;
    logic                     vga_hs_q, vga_hs_d, vga_vs_q, vga_vs_d;

    // Delay line for the per-pixel flags; the colour register is its final stage.
    stage_t pipe_q [0:c_mem_lat-1];
    stage_t pipe_d [0:c_mem_lat-1];
    stage_t cur_stage, last_stage;

    logic [2:0]  z_m1;
    logic [10:0] w, h, col_x, row_x, img_x, img_y;
    logic [10:0] bx_min, bx_max, by_min, by_max;
    logic        in_w, in_h, in_img, on_border, on_box;
    logic        box_ok, box_x_in, box_y_in;

    // ---------------- region decode (current pixel) ----------------
    assign col_x  = {1'b0, col};
    assign row_x  = {1'b0, row};
    assign w      = c_cols_s << zoom_q;
    assign h      = c_rows_s << zoom_q;
    assign in_w   = col_x < w;
    assign in_h   = row_x < h;
    assign in_img = in_w && in_h;
    assign img_x  = col_x >> zoom_q;
    assign img_y  = row_x >> zoom_q;
    assign bx_min = 11'(box_xmin);
    assign bx_max = 11'(box_xmax);
    assign by_min = 11'(box_ymin);
    assign by_max = 11'(box_ymax);

    // An inverted rectangle is treated as empty; without this gate the
    // xmin/ymin edges would still light up.
    assign box_ok   = (bx_min <= bx_max) && (by_min <= by_max);
    assign box_x_in = (img_x >= bx_min) && (img_x <= bx_max);
    assign box_y_in = (img_y >= by_min) && (img_y <= by_max);
    assign on_box   = box_en && in_img && box_ok &&
                      ((((img_x == bx_min) || (img_x == bx_max)) && box_y_in) ||
                       (((img_y == by_min) || (img_y == by_max)) && box_x_in));
    assign on_border = ((col_x == w) && (row_x <= h)) || ((row_x == h) && (col_x <= w));

    always_comb begin
        case (zoom_q)
            2'd0:    z_m1 = 3'd0;
            2'd1:    z_m1 = 3'd1;
            2'd2:    z_m1 = 3'd3;
            default: z_m1 = 3'd7;
        endcase
    end

    // ---------------- zoom latch and address generation ----------------
    always_comb begin
        vsync_d      = vsync;
        zoom_d       = (vsync_q && !vsync) ? zoom_sel : zoom_q;
        frame_addr_d = frame_addr_q;
        line_base_d  = line_base_q;
        hsub_d       = hsub_q;
        vsub_d       = vsub_q;
        if (!in_h) begin
            // Below the image: park everything at the frame origin.
            frame_addr_d = '0;
            line_base_d  = '0;
            hsub_d       = '0;
            vsub_d       = '0;
        end else if (new_pxl && in_w) begin
            if (col_x == w - 11'd1) begin
                hsub_d = '0;
                if (vsub_q == z_m1) begin
                    vsub_d = '0;
                    // After the last buffer line wrap to 0 instead of
                    // pointing one line past the end of the buffer.
                    if (line_base_q == c_last_line) begin
                        line_base_d  = '0;
                        frame_addr_d = '0;
                    end else begin
                        line_base_d  = line_base_q + c_line_step;
                        frame_addr_d = line_base_q + c_line_step;
                    end
                end else begin
                    vsub_d       = vsub_q + 3'd1;
                    frame_addr_d = line_base_q;   // replay the same buffer line
                end
            end else if (hsub_q == z_m1) begin
                hsub_d       = '0;
                frame_addr_d = frame_addr_q + 1'b1;
            end else begin
                hsub_d = hsub_q + 3'd1;
            end
        end
    end

    // ---------------- flag pipeline ----------------
    always_comb begin
        cur_stage = '{visible: visible, hsync: hsync, vsync: vsync,
                      in_img: in_img, on_border: on_border, on_box: on_box};
        pipe_d[0] = cur_stage;
        for (int i = 1; i < c_mem_lat; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    // ---------------- colour select (frame_pixel is aligned here) ----------------
    always_comb begin
        last_stage = pipe_q[c_mem_lat-1];
        red_d      = '0;
        green_d    = '0;
        blue_d     = '0;
        vga_hs_d   = last_stage.hsync;
        vga_vs_d   = last_stage.vsync;
        if (last_stage.visible) begin
            if (last_stage.on_box) begin
                red_d   = 4'hF;
                green_d = 4'hF;
            end else if (last_stage.in_img) begin
                if (rgbmode) begin
                    red_d   = 4'(frame_pixel[c_nb_buf-1 -: c_nb_buf_red]);
                    green_d = 4'(frame_pixel[c_nb_buf_blue +: c_nb_buf_green]);
                    blue_d  = 4'(frame_pixel[0 +: c_nb_buf_blue]);
                end else begin
                    red_d   = frame_pixel[7:4];
                    green_d = frame_pixel[7:4];
                    blue_d  = frame_pixel[7:4];
                end
            end else if (last_stage.on_border) begin
                green_d = 4'h8;
                blue_d  = 4'h8;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zoom_q       <= '0;
            vsync_q      <= 1'b1;
            frame_addr_q <= '0;
            line_base_q  <= '0;
            hsub_q       <= '0;
            vsub_q       <= '0;
            red_q        <= '0;
            green_q      <= '0;
            blue_q       <= '0;
            vga_hs_q     <= 1'b1;
            vga_vs_q     <= 1'b1;
            for (int i = 0; i < c_mem_lat; i++) begin
                pipe_q[i] <= c_stage_rst;
            end
        end else begin
            zoom_q       <= zoom_d;
            vsync_q      <= vsync_d;
            frame_addr_q <= frame_addr_d;
            line_base_q  <= line_base_d;
            hsub_q       <= hsub_d;
            vsub_q       <= vsub_d;
            red_q        <= red_d;
            green_q      <= green_d;
            blue_q       <= blue_d;
            vga_hs_q     <= vga_hs_d;
            vga_vs_q     <= vga_vs_d;
            pipe_q       <= pipe_d;
        end
    end

    assign frame_addr = frame_addr_q;
    assign vga_red    = red_q;
    assign vga_green  = green_q;
    assign vga_blue   = blue_q;
    assign vga_hsync  = vga_hs_q;
    assign vga_vsync  = vga_vs_q;

endmodule

// File: tb/tb_vga_display_zoom.sv
// -----------------------------------------------------------------------------
// tb_vga_display_zoom
//   Drives a truncated sync sequence (lines of arbitrary length, blanking rows
//   with a vsync pulse) through the zoom display with a 3-cycle frame-buffer
//   model and compares address and colour against a reference computed
//   directly from image coordinates.
// -----------------------------------------------------------------------------
module tb_vga_display_zoom;

    localparam int LAT  = 3;
    localparam int PER  = 5;     // clocks per VGA pixel, > LAT+1
    localparam int COLS = 80;
    localparam int ROWS = 60;

    logic        clk = 1'b0;
    logic        rst;
    logic        visible, new_pxl, hsync, vsync, rgbmode, box_en;
    logic [9:0]  col, row;
    logic [1:0]  zoom_sel;
    logic [6:0]  box_xmin, box_xmax;
    logic [5:0]  box_ymin, box_ymax;
    logic [11:0] frame_pixel;
    logic [12:0] frame_addr;
    logic [3:0]  vga_red, vga_green, vga_blue;
    logic        vga_hsync, vga_vsync;

    always #5 clk = ~clk;

    vga_display_zoom #(.c_mem_lat(LAT)) dut (
        .clk(clk), .rst(rst), .visible(visible), .new_pxl(new_pxl),
        .hsync(hsync), .vsync(vsync), .col(col), .row(row),
        .rgbmode(rgbmode), .zoom_sel(zoom_sel), .box_en(box_en),
        .box_xmin(box_xmin), .box_xmax(box_xmax),
        .box_ymin(box_ymin), .box_ymax(box_ymax),
        .frame_pixel(frame_pixel), .frame_addr(frame_addr),
        .vga_red(vga_red), .vga_green(vga_green), .vga_blue(vga_blue),
        .vga_hsync(vga_hsync), .vga_vsync(vga_vsync)
    );

    // Frame buffer with a three-register read path.
    logic [11:0] mem [0:COLS*ROWS-1];
    logic [11:0] m1, m2;
    always @(posedge clk) begin
        m1          <= mem[frame_addr];
        m2          <= m1;
        frame_pixel <= m2;
    end

    typedef struct {
        int         c;
        int         r;
        logic [11:0] rgb;
        logic       hs;
        logic       vs;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   zq_m    = 0;       // zoom in force for the current frame
    bit   prev_blank = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected output for one screen position, straight from image coordinates.
    function automatic exp_t model(int c, int r, logic vis, logic hs, logic vs);
        exp_t e;
        int z, wd, ht, x, y;
        bit in_img, box_ok, on_box, border;
        logic [11:0] px;
        z  = 1 << zq_m;
        wd = COLS * z;
        ht = ROWS * z;
        x  = c / z;
        y  = r / z;
        in_img = (c < wd) && (r < ht);
        box_ok = (box_xmin <= box_xmax) && (box_ymin <= box_ymax);
        on_box = box_en && in_img && box_ok &&
                 ((((x == box_xmin) || (x == box_xmax)) && (y >= box_ymin) && (y <= box_ymax)) ||
                  (((y == box_ymin) || (y == box_ymax)) && (x >= box_xmin) && (x <= box_xmax)));
        border = ((c == wd) && (r <= ht)) || ((r == ht) && (c <= wd));
        e.c = c; e.r = r; e.hs = hs; e.vs = vs; e.rgb = 12'h000;
        if (vis) begin
            if (on_box) e.rgb = 12'hFF0;
            else if (in_img) begin
                px    = mem[y*COLS + x];
                e.rgb = rgbmode ? px : {px[7:4], px[7:4], px[7:4]};
            end else if (border) e.rgb = 12'h088;
        end
        return e;
    endfunction

    task automatic step(input int c, input int r, input logic vis, input logic hs,
                        input logic vs, input logic np);
        exp_t e;
        int z;
        col = 10'(c); row = 10'(r); visible = vis; hsync = hs; vsync = vs; new_pxl = np;
        z = 1 << zq_m;
        if (r < ROWS*z && c < COLS*z)
            chk($sformatf("addr@%0d,%0d", c, r), 32'(frame_addr), 32'((r/z)*COLS + c/z));
        else if (r >= ROWS*z && prev_blank)
            chk($sformatf("addr_blank@%0d,%0d", c, r), 32'(frame_addr), 32'd0);
        prev_blank = (r >= ROWS*z);
        q.push_back(model(c, r, vis, hs, vs));
        @(posedge clk); #1;
        if (q.size() == LAT + 1) begin
            e = q.pop_front();
            chk($sformatf("vga@%0d,%0d", e.c, e.r),
                32'({vga_red, vga_green, vga_blue, vga_hsync, vga_vsync}),
                32'({e.rgb, e.hs, e.vs}));
        end
    endtask

    task automatic pix(input int c, input int r, input logic vis, input logic hs, input logic vs);
        for (int p = 0; p < PER; p++) step(c, r, vis, hs, vs, p == PER-1);
    endtask

    task automatic line(input int r, input int ncols, input logic vs);
        for (int c = 0; c < ncols; c++) pix(c, r, (c < 640) && (r < 480), 1'b1, vs);
        pix(700, r, 1'b0, 1'b0, vs);   // hsync pulse
    endtask

    task automatic frame(input int nrows, input int ncols);
        for (int r = 0; r < nrows; r++) line(r, ncols, 1'b1);
    endtask

    // Blanking rows with a vsync pulse; zoom_sel takes effect from here.
    task automatic blank();
        line(490, 4, 1'b1);
        zq_m = int'(zoom_sel);
        line(491, 4, 1'b0);
        line(492, 4, 1'b1);
    endtask

    initial begin
        for (int i = 0; i < COLS*ROWS; i++) mem[i] = 12'($urandom);
        mem[5] = 12'hA5C;
        mem[1] = 12'h0B3;
        rst = 1'b1;
        col = '0; row = '0; visible = 1'b0; new_pxl = 1'b0; hsync = 1'b1; vsync = 1'b1;
        rgbmode = 1'b1; zoom_sel = 2'd0; box_en = 1'b0;
        box_xmin = '0; box_xmax = '0; box_ymin = '0; box_ymax = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_addr", 32'(frame_addr), 32'd0);
        chk("rst_rgb", 32'({vga_red, vga_green, vga_blue}), 32'd0);
        chk("rst_sync", 32'({vga_hsync, vga_vsync}), 32'b11);
        rst = 1'b0;

        // x1 full frame; a zoom request mid-frame must wait for vsync.
        for (int r = 0; r <= ROWS; r++) begin
            if (r == 30) zoom_sel = 2'd3;
            line(r, COLS + 2, 1'b1);
        end
        blank();

        // x8: two lines across the whole screen width.
        rgbmode  = 1'($urandom_range(0, 1));
        zoom_sel = 2'd2;
        frame(2, 640);
        blank();

        // x4 grey: border column 320 and border row 240.
        rgbmode  = 1'b0;
        zoom_sel = 2'd1;
        frame(6, 4*COLS + 2);
        line(4*ROWS, 4*COLS + 2, 1'b1);
        blank();

        // x2 with the bounding box.
        rgbmode  = 1'($urandom_range(0, 1));
        box_en   = 1'b1;
        box_xmin = 7'd10; box_xmax = 7'd20; box_ymin = 6'd5; box_ymax = 6'd8;
        frame(19, 2*COLS + 2);
        blank();

        // x2 with an inverted box, then a reset in the middle of a line.
        box_xmin = 7'd30; box_xmax = 7'd20;
        frame(12, 2*COLS + 2);
        for (int c = 0; c < 40; c++) pix(c, 12, 1'b1, 1'b1, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_addr", 32'(frame_addr), 32'd0);
        chk("midrst_rgb", 32'({vga_red, vga_green, vga_blue}), 32'd0);
        chk("midrst_sync", 32'({vga_hsync, vga_vsync}), 32'b11);
        q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        zq_m = 0;
        prev_blank = 1'b0;

        // Restart without a vsync: zoom must be back at x1 despite zoom_sel=1.
        line(490, 4, 1'b1);
        line(492, 4, 1'b1);
        rgbmode = 1'b1;
        frame(2, COLS + 2);
        blank();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
